// File: rtl/mips_pkg.sv
// Shared definitions for the MEM stage: WBM control-field bit positions and FSM states.
package mips_pkg;

  localparam int WBM_REGWR   = 3;
  localparam int WBM_MEM2REG = 2;
  localparam int WBM_MEMRD   = 1;
  localparam int WBM_MEMWR   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } mem_state_e;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Clearable watchdog counter; saturates at all-ones and flags terminal count.
module mem_timeout_ctr #(
  parameter int W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !tc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = &count;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: data-memory handshake, upstream stall and MEM/WB register.
// Optional build macro MEM_ALIGN_CHECK_EN traps unaligned accesses instead of aligning them.
module mem_stage_ctrl
  import mips_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [4:0]        dst_reg,
  input  logic [3:0]        wbm,
  output logic              stall_out,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [4:0]        wb_dst_reg,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [DATA_W-1:0] wb_load_data,
  output logic              bus_err,
  output logic              misalign_exc
);

  mem_state_e        state, state_next;
  logic              mem_op, misaligned;
  logic              capture, abort, ctr_clear, ctr_en, ctr_tc;
  logic [DATA_W-1:0] addr_q, wdata_q, rdata_q;
  logic [4:0]        dst_q;
  logic              we_q, regwr_q, mem2reg_q, err_q, mis_q;

  assign mem_op = in_valid & (wbm[WBM_MEMRD] | wbm[WBM_MEMWR]);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (alu_result[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  mem_timeout_ctr #(.W(TIMEOUT_W)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (ctr_clear),
    .enable (ctr_en),
    .tc     (ctr_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Completion on the terminal-count cycle wins over the timeout abort.
  always_comb begin
    state_next = state;
    stall_out  = 1'b0;
    dmem_req   = 1'b0;
    ctr_clear  = 1'b0;
    ctr_en     = 1'b0;
    capture    = 1'b0;
    abort      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (mem_op) begin
          stall_out  = 1'b1;
          ctr_clear  = 1'b1;
          state_next = misaligned ? ST_RESP : ST_REQ;
        end
      end
      ST_REQ: begin
        stall_out = 1'b1;
        dmem_req  = 1'b1;
        ctr_en    = 1'b1;
        if (dmem_gnt) begin
          if (we_q) begin
            state_next = ST_RESP;
          end else if (dmem_rvalid) begin
            capture    = 1'b1;
            state_next = ST_RESP;
          end else begin
            state_next = ST_WAIT;
          end
        end else if (ctr_tc) begin
          abort      = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_WAIT: begin
        stall_out = 1'b1;
        ctr_en    = 1'b1;
        if (dmem_rvalid) begin
          capture    = 1'b1;
          state_next = ST_RESP;
        end else if (ctr_tc) begin
          abort      = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The access is latched on acceptance so the bus sees stable values even if inputs wiggle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      dst_q     <= '0;
      we_q      <= 1'b0;
      regwr_q   <= 1'b0;
      mem2reg_q <= 1'b0;
      err_q     <= 1'b0;
      mis_q     <= 1'b0;
    end else if (state == ST_IDLE && mem_op) begin
      addr_q    <= alu_result;
      wdata_q   <= store_data;
      rdata_q   <= '0;
      dst_q     <= dst_reg;
      we_q      <= wbm[WBM_MEMWR];
      regwr_q   <= wbm[WBM_REGWR];
      mem2reg_q <= wbm[WBM_MEM2REG];
      err_q     <= 1'b0;
      mis_q     <= misaligned;
    end else if (capture) begin
      rdata_q <= dmem_rdata;
    end else if (abort) begin
      err_q <= 1'b1;
    end
  end

  assign dmem_we    = we_q;
  assign dmem_addr  = {addr_q[DATA_W-1:2], 2'b00};
  assign dmem_wdata = wdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_dst_reg    <= '0;
      wb_alu_result <= '0;
      wb_load_data  <= '0;
      bus_err       <= 1'b0;
      misalign_exc  <= 1'b0;
    end else if (state == ST_RESP) begin
      wb_valid      <= 1'b1;
      wb_reg_write  <= regwr_q & ~err_q & ~mis_q;
      wb_mem_to_reg <= mem2reg_q;
      wb_dst_reg    <= dst_q;
      wb_alu_result <= addr_q;
      wb_load_data  <= rdata_q;
      bus_err       <= err_q;
      misalign_exc  <= mis_q;
    end else if (in_valid && !stall_out) begin
      wb_valid      <= 1'b1;
      wb_reg_write  <= wbm[WBM_REGWR];
      wb_mem_to_reg <= wbm[WBM_MEM2REG];
      wb_dst_reg    <= dst_reg;
      wb_alu_result <= alu_result;
      wb_load_data  <= '0;
      bus_err       <= 1'b0;
      misalign_exc  <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      bus_err      <= 1'b0;
      misalign_exc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl; expected timing and results come from a transaction-level model.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] alu_result, store_data, dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] wb_alu_result, wb_load_data;
  logic [4:0]  dst_reg, wb_dst_reg;
  logic [3:0]  wbm;
  logic        stall_out, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic        wb_valid, wb_reg_write, wb_mem_to_reg, bus_err, misalign_exc;

  int checks = 0;
  int errors = 0;

  mem_stage_ctrl #(.DATA_W(32), .TIMEOUT_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .alu_result    (alu_result),
    .store_data    (store_data),
    .dst_reg       (dst_reg),
    .wbm           (wbm),
    .stall_out     (stall_out),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_gnt      (dmem_gnt),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_mem_to_reg (wb_mem_to_reg),
    .wb_dst_reg    (wb_dst_reg),
    .wb_alu_result (wb_alu_result),
    .wb_load_data  (wb_load_data),
    .bus_err       (bus_err),
    .misalign_exc  (misalign_exc)
  );

  always #5 clk = ~clk;

  // Memory responder: grants after g request cycles (g<0 never), rvalid r cycles after grant.
  task automatic do_mem(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] w,
                        input logic [4:0] dst, input int g, input int r, input logic [31:0] rd,
                        output int stall_cycles, output int req_cycles, output logic we_seen,
                        output logic [31:0] addr_seen, output logic [31:0] wdata_seen,
                        output logic timed_out);
    int gcnt, wcnt;
    logic granted;
    stall_cycles = 0; req_cycles = 0; we_seen = 1'b0; addr_seen = '0; wdata_seen = '0;
    timed_out = 1'b1; gcnt = 0; wcnt = 0; granted = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; alu_result = addr; store_data = data; wbm = w; dst_reg = dst;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
    for (int cyc = 0; cyc < 400; cyc++) begin
      #1;
      dmem_gnt = 1'b0;
      dmem_rvalid = 1'b0;
      if (!stall_out) begin
        timed_out = 1'b0;
        break;
      end
      stall_cycles++;
      if (dmem_req) begin
        req_cycles++;
        we_seen = dmem_we; addr_seen = dmem_addr; wdata_seen = dmem_wdata;
        if (g >= 0 && gcnt == g) begin
          dmem_gnt = 1'b1;
          granted  = 1'b1;
          if (r == 0) begin dmem_rvalid = 1'b1; dmem_rdata = rd; end
        end
        gcnt++;
      end else if (granted) begin
        wcnt++;
        if (wcnt == r) begin dmem_rvalid = 1'b1; dmem_rdata = rd; end
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0; alu_result = '0; store_data = '0; dst_reg = '0; wbm = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({stall_out, dmem_req, dmem_we, dmem_addr, dmem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_bus: got req=%b we=%b stall=%b addr=%h wdata=%h, expected all 0",
               dmem_req, dmem_we, stall_out, dmem_addr, dmem_wdata);
    end
    checks++;
    if ({wb_valid, wb_reg_write, wb_mem_to_reg, wb_dst_reg, wb_alu_result, wb_load_data,
         bus_err, misalign_exc} !== '0) begin
      errors++;
      $display("FAIL reset_wb: got valid=%b rw=%b alu=%h load=%h err=%b mis=%b, expected all 0",
               wb_valid, wb_reg_write, wb_alu_result, wb_load_data, bus_err, misalign_exc);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Back-to-back non-memory ops: never stall, each appears on MEM/WB one edge later.
  task automatic test_alu_ops();
    logic [31:0] a;
    logic [4:0]  d;
    logic [3:0]  w;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a = (i == 0) ? 32'h1234 : $urandom;
      d = (i == 0) ? 5'd5 : 5'($urandom);
      w = (i == 0) ? 4'b1000 : {2'($urandom), 2'b00};
      in_valid = 1'b1; alu_result = a; dst_reg = d; wbm = w; store_data = $urandom;
      #1;
      checks++;
      if (stall_out !== 1'b0 || dmem_req !== 1'b0) begin
        errors++;
        $display("FAIL alu_stall[%0d]: got stall=%b req=%b, expected 0/0", i, stall_out, dmem_req);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({wb_valid, wb_reg_write, wb_mem_to_reg, wb_dst_reg, wb_alu_result, wb_load_data}
          !== {1'b1, w[3], w[2], d, a, 32'h0}) begin
        errors++;
        $display("FAIL alu_wb[%0d]: got v=%b rw=%b m2r=%b dst=%0d alu=%h ld=%h, expected 1 %b %b %0d %h 0",
                 i, wb_valid, wb_reg_write, wb_mem_to_reg, wb_dst_reg, wb_alu_result,
                 wb_load_data, w[3], w[2], d, a);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL alu_bubble: got wb_valid=%b, expected 0", wb_valid);
    end
  endtask

  task automatic test_mem_access();
    logic [31:0] addr, data, rd, aseen, dseen;
    logic [3:0]  w;
    logic [4:0]  dst;
    logic        wseen, tout, is_wr;
    int          g, r, sc, rc, exp_stall;
    for (int i = 0; i < 14; i++) begin
      if (i == 0) begin
        addr = 32'h40; data = $urandom; w = 4'b1110; dst = 5'd7; g = 0; r = 0; rd = 32'h0BADF00D;
      end else if (i == 1) begin
        addr = 32'h80; data = 32'hCAFE; w = 4'b0001; dst = 5'd0; g = 3; r = 0; rd = $urandom;
      end else begin
        is_wr = 1'($urandom);
        addr = $urandom & 32'hFFFF_FFFC; data = $urandom; dst = 5'($urandom);
        w = is_wr ? {2'($urandom), 1'($urandom), 1'b1} : {2'($urandom), 2'b10};
        g = $urandom_range(0, 5); r = $urandom_range(0, 4); rd = $urandom;
      end
      is_wr = w[0];
      exp_stall = is_wr ? g + 2 : g + 2 + r;
      do_mem(addr, data, w, dst, g, r, rd, sc, rc, wseen, aseen, dseen, tout);
      checks++;
      if (tout !== 1'b0 || sc != exp_stall || rc != g + 1) begin
        errors++;
        $display("FAIL mem_timing[%0d]: got stall=%0d req=%0d hung=%b, expected stall=%0d req=%0d hung=0",
                 i, sc, rc, tout, exp_stall, g + 1);
      end
      checks++;
      if (wseen !== is_wr || aseen !== {addr[31:2], 2'b00} || (is_wr && dseen !== data)) begin
        errors++;
        $display("FAIL mem_bus[%0d]: got we=%b addr=%h wdata=%h, expected we=%b addr=%h wdata=%h",
                 i, wseen, aseen, dseen, is_wr, {addr[31:2], 2'b00}, data);
      end
      checks++;
      if ({wb_valid, wb_reg_write, wb_mem_to_reg, wb_dst_reg, wb_alu_result, bus_err, misalign_exc}
          !== {1'b1, w[3], w[2], dst, addr, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL mem_wb[%0d]: got v=%b rw=%b m2r=%b dst=%0d alu=%h err=%b mis=%b, expected 1 %b %b %0d %h 0 0",
                 i, wb_valid, wb_reg_write, wb_mem_to_reg, wb_dst_reg, wb_alu_result, bus_err,
                 misalign_exc, w[3], w[2], dst, addr);
      end
      if (!is_wr) begin
        checks++;
        if (wb_load_data !== rd) begin
          errors++;
          $display("FAIL mem_load_data[%0d]: got %h, expected %h", i, wb_load_data, rd);
        end
      end
      @(posedge clk);
      #1;
      checks++;
      if (wb_valid !== 1'b0) begin
        errors++;
        $display("FAIL mem_bubble[%0d]: got wb_valid=%b, expected 0", i, wb_valid);
      end
    end
  endtask

  task automatic test_timeout();
    logic [31:0] aseen, dseen;
    logic        wseen, tout;
    int          sc, rc;
    do_mem(32'h100, 32'h0, 4'b1110, 5'd9, -1, 0, 32'h0, sc, rc, wseen, aseen, dseen, tout);
    checks++;
    if (tout !== 1'b0 || sc < 256 || sc > 260) begin
      errors++;
      $display("FAIL timeout_stall: got stall=%0d hung=%b, expected 256..260 and hung=0", sc, tout);
    end
    checks++;
    if ({wb_valid, bus_err, wb_reg_write, wb_load_data} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL timeout_wb: got v=%b err=%b rw=%b ld=%h, expected 1 1 0 0",
               wb_valid, bus_err, wb_reg_write, wb_load_data);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus_err !== 1'b0 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: got err=%b req=%b, expected 0 0", bus_err, dmem_req);
    end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    in_valid = 1'b1; alu_result = 32'h200; wbm = 4'b1110; dst_reg = 5'd3;
    @(posedge clk);
    #1;
    checks++;
    if (dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_req_on: got dmem_req=%b, expected 1", dmem_req);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_req_drop: got dmem_req=%b, expected 0", dmem_req);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #2 dmem_gnt = 1'b1;
    @(posedge clk);
    #1 dmem_gnt = 1'b0;
    checks++;
    if (dmem_req !== 1'b0 || stall_out !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait_state: got req=%b stall=%b, expected 0 1", dmem_req, stall_out);
    end
    #2 reset = 1'b1; in_valid = 1'b0;
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dmem_rvalid = (i < 2); dmem_rdata = $urandom;
      @(posedge clk);
      #1;
      checks++;
      if (wb_valid !== 1'b0 || stall_out !== 1'b0 || dmem_req !== 1'b0) begin
        errors++;
        $display("FAIL rst_stray_rvalid[%0d]: got v=%b stall=%b req=%b, expected 0 0 0",
                 i, wb_valid, stall_out, dmem_req);
      end
    end
    dmem_rvalid = 1'b0;
  endtask

  task automatic test_misalign();
    logic [31:0] aseen, dseen;
    logic        wseen, tout;
    int          sc, rc;
    do_mem(32'h42, 32'h0, 4'b1110, 5'd4, 0, 0, 32'h1357_9BDF, sc, rc, wseen, aseen, dseen, tout);
`ifdef MEM_ALIGN_CHECK_EN
    checks++;
    if (tout !== 1'b0 || rc != 0 || sc != 1) begin
      errors++;
      $display("FAIL misalign_noreq: got req=%0d stall=%0d hung=%b, expected 0 1 0", rc, sc, tout);
    end
    checks++;
    if ({wb_valid, misalign_exc, wb_reg_write, bus_err} !== 4'b1100) begin
      errors++;
      $display("FAIL misalign_wb: got v=%b mis=%b rw=%b err=%b, expected 1 1 0 0",
               wb_valid, misalign_exc, wb_reg_write, bus_err);
    end
`else
    checks++;
    if (tout !== 1'b0 || rc != 1 || sc != 2 || aseen !== 32'h40) begin
      errors++;
      $display("FAIL align_ignored: got req=%0d stall=%0d addr=%h, expected 1 2 00000040", rc, sc, aseen);
    end
    checks++;
    if ({wb_valid, misalign_exc, wb_reg_write} !== 3'b101 || wb_load_data !== 32'h1357_9BDF) begin
      errors++;
      $display("FAIL align_wb: got v=%b mis=%b rw=%b ld=%h, expected 1 0 1 13579bdf",
               wb_valid, misalign_exc, wb_reg_write, wb_load_data);
    end
`endif
    @(posedge clk);
    #1;
    checks++;
    if (misalign_exc !== 1'b0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL misalign_pulse: got mis=%b v=%b, expected 0 0", misalign_exc, wb_valid);
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_mem_access();
    test_timeout();
    test_reset_mid_access();
    test_misalign();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
